// File: rtl/fft_vis_pkg.sv
// Shared definitions for the FFT-to-visualizer frame write path.
package fft_vis_pkg;

   localparam int N_BINS = 512;
   localparam int ADDR_W = 9;
   localparam int MAG_W  = 24;
   localparam int CNT_W  = 16;

   // Frame sequencer states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      READY   = 2'd3
   } fsm_state_t;

endpackage

// File: rtl/fft_frame_write_ctrl_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = fft_vis_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   // Increment on each pulse unless already at the ceiling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/fft_frame_write_ctrl.sv
// Frame write sequencer: forwards complete, in-order FFT frames into the
// back bank of the double-buffered visualizer and swaps banks on vsync.
module fft_frame_write_ctrl #(
   parameter int N_BINS = fft_vis_pkg::N_BINS,
   parameter int ADDR_W = fft_vis_pkg::ADDR_W,
   parameter int MAG_W  = fft_vis_pkg::MAG_W,
   parameter int CNT_W  = fft_vis_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic [3:0]        i_decim,
   input  logic [ADDR_W-1:0] i_fft_addr,
   input  logic [MAG_W-1:0]  i_fft_mag,
   input  logic              i_fft_valid,
   input  logic              i_vsync_tick,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [MAG_W-1:0]  o_wr_mag,
   output logic              o_wr_valid,
   output logic              o_wr_bank,
   output logic              o_rd_bank,
   output logic              o_swap,
   output logic              o_seq_err,
   output logic [CNT_W-1:0]  o_drop_cnt,
   output logic [CNT_W-1:0]  o_err_cnt
);

   import fft_vis_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS - 1);

   fsm_state_t        state_reg;
   logic [ADDR_W-1:0] expected_reg;
   logic [3:0]        skip_reg;
   logic              rd_bank_reg;
   logic              swap_reg;
   logic              seq_err_reg;
   logic              wr_valid_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [MAG_W-1:0]  wr_mag_reg;

   logic frame_start;
   logic drop_inc;
   logic err_inc;

   assign frame_start = i_fft_valid && (i_fft_addr == '0);

   // Decode which cycles lose a frame or break the bin sequence
   always_comb begin
      drop_inc = 1'b0;
      err_inc  = 1'b0;
      case (state_reg)
         ARMED: begin
            if (i_enable && frame_start && (skip_reg != 4'd0)) drop_inc = 1'b1;
         end
         CAPTURE: begin
            if (!i_enable) begin
               drop_inc = 1'b1;
            end else if (i_fft_valid && (i_fft_addr != expected_reg)) begin
               drop_inc = 1'b1;
               err_inc  = 1'b1;
            end
         end
         READY: begin
            if (frame_start) drop_inc = 1'b1;
         end
         default: ;
      endcase
   end

   // Frame sequencer with registered write port, swap and error pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         expected_reg <= '0;
         skip_reg     <= 4'd0;
         rd_bank_reg  <= 1'b0;
         swap_reg     <= 1'b0;
         seq_err_reg  <= 1'b0;
         wr_valid_reg <= 1'b0;
         wr_addr_reg  <= '0;
         wr_mag_reg   <= '0;
      end else begin
         wr_valid_reg <= 1'b0;
         swap_reg     <= 1'b0;
         seq_err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (i_enable) state_reg <= ARMED;
            end
            ARMED: begin
               if (!i_enable) begin
                  state_reg <= IDLE;
               end else if (frame_start) begin
                  if (skip_reg == 4'd0) begin
                     wr_valid_reg <= 1'b1;
                     wr_addr_reg  <= i_fft_addr;
                     wr_mag_reg   <= i_fft_mag;
                     expected_reg <= ADDR_W'(1);
                     state_reg    <= CAPTURE;
                  end else begin
                     skip_reg <= skip_reg - 4'd1;
                  end
               end
            end
            CAPTURE: begin
               if (!i_enable) begin
                  state_reg <= IDLE;
               end else if (i_fft_valid) begin
                  if (i_fft_addr == expected_reg) begin
                     wr_valid_reg <= 1'b1;
                     wr_addr_reg  <= i_fft_addr;
                     wr_mag_reg   <= i_fft_mag;
                     if (expected_reg == LAST_BIN) begin
                        skip_reg  <= i_decim;
                        state_reg <= READY;
                     end else begin
                        expected_reg <= expected_reg + 1'b1;
                     end
                  end else begin
                     seq_err_reg <= 1'b1;
                     // A fresh bin 0 restarts the frame rather than waiting for the next one
                     if ((i_fft_addr == '0) && (skip_reg == 4'd0)) begin
                        wr_valid_reg <= 1'b1;
                        wr_addr_reg  <= i_fft_addr;
                        wr_mag_reg   <= i_fft_mag;
                        expected_reg <= ADDR_W'(1);
                     end else begin
                        state_reg <= ARMED;
                     end
                  end
               end
            end
            READY: begin
               // Completed frame stays pending until vsync, even if capture is disabled
               if (i_vsync_tick) begin
                  rd_bank_reg <= ~rd_bank_reg;
                  swap_reg    <= 1'b1;
                  state_reg   <= i_enable ? ARMED : IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (drop_inc),
      .count (o_drop_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_inc),
      .count (o_err_cnt)
   );

   assign o_wr_valid = wr_valid_reg;
   assign o_wr_addr  = wr_addr_reg;
   assign o_wr_mag   = wr_mag_reg;
   assign o_rd_bank  = rd_bank_reg;
   assign o_wr_bank  = ~rd_bank_reg;
   assign o_swap     = swap_reg;
   assign o_seq_err  = seq_err_reg;

endmodule
